pe_array_seq: RTL



---
 rtl/pe_pkg.sv | 14 +
 rtl/pe_array_seq_if.sv | 31 +++
 rtl/pe_loop_cnt.sv | 50 +++++
 rtl/pe_array_seq.sv | 109 ++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared constants, FSM states and lane helper for the pe_array sequencer
package pe_pkg;
    localparam int MAC_NUM = 10;
    localparam int BW_ACT  = 8;
    localparam int BW_WET  = 8;
    localparam int ADDR_W  = 16;
    localparam int RES_LAT = 3;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, DONE} state_t;

    function automatic logic [BW_ACT-1:0] lane(input logic [MAC_NUM*BW_ACT-1:0] v, input int n);
        return v[n*BW_ACT +: BW_ACT];
    endfunction
endpackage

// File: rtl/pe_array_seq_if.sv
// pe_array_seq_if: buffer reads, pe_array drive and output-write handshake of the sequencer
interface pe_array_seq_if;
    import pe_pkg::*;
    logic                      act_rd_en;
    logic [ADDR_W-1:0]         act_rd_addr;
    logic [MAC_NUM*BW_ACT-1:0] act_rd_data;
    logic                      wet_rd_en;
    logic [ADDR_W-1:0]         wet_rd_addr;
    logic [BW_WET-1:0]         wet_rd_data;
    logic                      pe_mac_enable;
    logic                      pe_clear_acc;
    logic [MAC_NUM*BW_ACT-1:0] pe_act_in;
    logic [BW_WET-1:0]         pe_wet_in;
    logic [7:0]                pe_res_shift_num;
    logic [MAC_NUM*BW_ACT-1:0] pe_result_in;
    logic                      out_wr_en;
    logic [ADDR_W-1:0]         out_wr_addr;
    logic [MAC_NUM*BW_ACT-1:0] out_wr_data;
    logic                      out_wr_ready;

    modport master (
        output act_rd_en, act_rd_addr, wet_rd_en, wet_rd_addr, pe_mac_enable, pe_clear_acc,
               pe_act_in, pe_wet_in, pe_res_shift_num, out_wr_en, out_wr_addr, out_wr_data,
        input  act_rd_data, wet_rd_data, pe_result_in, out_wr_ready
    );
    modport slave (
        input  act_rd_en, act_rd_addr, wet_rd_en, wet_rd_addr, pe_mac_enable, pe_clear_acc,
               pe_act_in, pe_wet_in, pe_res_shift_num, out_wr_en, out_wr_addr, out_wr_data,
        output act_rd_data, wet_rd_data, pe_result_in, out_wr_ready
    );
endinterface

// File: rtl/pe_loop_cnt.sv
// pe_loop_cnt: i/j/m loop counters with last-flags and adder-only buffer addresses
module pe_loop_cnt
    import pe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              step_i,
    input  logic              tile_adv,
    input  logic [9:0]        cfg_k,
    input  logic [7:0]        cfg_n,
    input  logic [7:0]        cfg_tiles,
    output logic              last_i,
    output logic              last_tile,
    output logic [ADDR_W-1:0] act_addr,
    output logic [ADDR_W-1:0] wet_addr,
    output logic [ADDR_W-1:0] out_addr
);
    logic [9:0]        i;
    logic [7:0]        j, m;
    logic [ADDR_W-1:0] act_base;
    logic              last_j;

    assign last_i    = i == cfg_k - 1'b1;
    assign last_j    = j == cfg_tiles - 1'b1;
    assign last_tile = last_j && m == cfg_n - 1'b1;
    assign act_addr  = act_base + ADDR_W'(i);

    // i steps through the reduction; a tile advance moves j (wrapping into m) and rebases addresses
    always_ff @(posedge clk) begin
        if (reset || init) begin
            i        <= '0;
            j        <= '0;
            m        <= '0;
            act_base <= '0;
            wet_addr <= '0;
            out_addr <= '0;
        end else if (step_i && !last_i) begin
            i        <= i + 1'b1;
            wet_addr <= wet_addr + ADDR_W'(cfg_n);
        end else if (tile_adv) begin
            i        <= '0;
            j        <= last_j ? '0 : j + 1'b1;
            m        <= last_j ? m + 1'b1 : m;
            act_base <= last_j ? '0 : act_base + ADDR_W'(cfg_k);
            wet_addr <= last_j ? ADDR_W'(m) + 1'b1 : ADDR_W'(m);
            out_addr <= last_j ? ADDR_W'(m) + 1'b1 : out_addr + ADDR_W'(cfg_n);
        end
    end
endmodule

// File: rtl/pe_array_seq.sv
// pe_array_seq: GEMM loop-nest sequencer feeding pe_array and writing each tile's results
module pe_array_seq
    import pe_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [9:0]     cfg_k,
    input  logic [7:0]     cfg_n,
    input  logic [7:0]     cfg_tiles,
    input  logic [7:0]     cfg_shift,
    output logic           busy,
    output logic           done,
    output logic           cfg_err,
    pe_array_seq_if.master bus
);
    localparam int DW = $clog2(RES_LAT + 1);

    state_t                    state, state_nx;
    logic [9:0]                k_q;
    logic [7:0]                n_q, tiles_q, shift_q;
    logic [DW-1:0]             drain_cnt;
    logic                      mac_q, err_q;
    logic [MAC_NUM*BW_ACT-1:0] res_q;
    logic                      cfg_ok, launch, drain_last, xfer, last_i, last_tile;
    logic [ADDR_W-1:0]         act_addr, wet_addr, out_addr;

    assign cfg_ok     = cfg_k != '0 && cfg_n != '0 && cfg_tiles != '0;
    assign launch     = state == IDLE && start && cfg_ok;
    assign drain_last = drain_cnt == DW'(RES_LAT);
    assign xfer       = state == WRITE && bus.out_wr_ready;

    pe_loop_cnt u_cnt (
        .clk       (clk),
        .reset     (reset),
        .init      (launch),
        .step_i    (state == FEED),
        .tile_adv  (xfer),
        .cfg_k     (k_q),
        .cfg_n     (n_q),
        .cfg_tiles (tiles_q),
        .last_i    (last_i),
        .last_tile (last_tile),
        .act_addr  (act_addr),
        .wet_addr  (wet_addr),
        .out_addr  (out_addr)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state: clear, feed cfg_k beats, drain the pe pipeline, hand off the tile
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = launch ? CLEAR : IDLE;
            CLEAR:   state_nx = FEED;
            FEED:    state_nx = last_i ? DRAIN : FEED;
            DRAIN:   state_nx = drain_last ? WRITE : DRAIN;
            WRITE:   state_nx = xfer ? (last_tile ? DONE : CLEAR) : WRITE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // job config latch, read-to-MAC delay, drain timer and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q       <= '0;
            n_q       <= '0;
            tiles_q   <= '0;
            shift_q   <= '0;
            drain_cnt <= '0;
            mac_q     <= 1'b0;
            err_q     <= 1'b0;
            res_q     <= '0;
        end else begin
            mac_q     <= state == FEED;
            err_q     <= state == IDLE && start && !cfg_ok;
            drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
            if (launch) begin
                k_q     <= cfg_k;
                n_q     <= cfg_n;
                tiles_q <= cfg_tiles;
                shift_q <= cfg_shift;
            end
            if (state == DRAIN && drain_last) res_q <= bus.pe_result_in;
        end
    end

    assign busy                 = state != IDLE;
    assign done                 = state == DONE;
    assign cfg_err              = err_q;
    assign bus.act_rd_en        = state == FEED;
    assign bus.wet_rd_en        = state == FEED;
    assign bus.act_rd_addr      = bus.act_rd_en ? act_addr : '0;
    assign bus.wet_rd_addr      = bus.wet_rd_en ? wet_addr : '0;
    assign bus.pe_mac_enable    = mac_q;
    assign bus.pe_clear_acc     = state == CLEAR;
    assign bus.pe_act_in        = mac_q ? bus.act_rd_data : '0;
    assign bus.pe_wet_in        = mac_q ? bus.wet_rd_data : '0;
    assign bus.pe_res_shift_num = busy ? shift_q : '0;
    assign bus.out_wr_en        = state == WRITE;
    assign bus.out_wr_addr      = bus.out_wr_en ? out_addr : '0;
    assign bus.out_wr_data      = res_q;
endmodule
